ifmap_glb_reader: RTL and testbench

//  Sits directly downstream of the ifmap GLB. Drives its 16-bit port B to read a

---
 rtl/ifmap_glb_reader.sv | 193 +++++++++++++++++++
 tb/tb_ifmap_glb_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ifmap_glb_reader.sv
// Reads a rows x cols ifmap tile out of GLB port B and streams it downstream over valid/ready.
// A 2-entry fall-through buffer plus read credits absorb the 1-cycle GLB latency and back-pressure.
module ifmap_glb_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 16,
    parameter int CNT_WIDTH  = 8,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  row_cnt,
    input  logic [CNT_WIDTH-1:0]  col_cnt,
    input  logic [CNT_WIDTH-1:0]  row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  re_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d, stride_q, stride_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic                  in_flight_q, in_flight_d, flight_last_q, flight_last_d;
    logic                  done_q, done_d;
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic                  buf_last_q [2];
    logic                  buf_last_d [2];

    logic                  buf_empty, credit_ok, issue, push, pop, accept;
    logic                  row_end, last_elem, zero_cfg;
    logic [ADDR_WIDTH-1:0] cur_addr;

    assign buf_empty = (occ_q == 2'd0);
    assign credit_ok = (occ_q + {1'b0, in_flight_q}) < 2'd2;
    assign issue     = (state_q == ISSUE) && credit_ok;
    assign push      = in_flight_q;
    assign pop       = m_valid && m_ready;
    assign accept    = start && (state_q == IDLE) && !done_q;
    assign zero_cfg  = (row_cnt == '0) || (col_cnt == '0);
    assign row_end   = (col_q == cols_q - CNT_WIDTH'(1));
    assign last_elem = row_end && (row_q == rows_q - CNT_WIDTH'(1));
    assign cur_addr  = ADDR_WIDTH'(CNT_WIDTH'(row_base_q) + col_q);

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign re_b   = issue;
    assign addr_b = issue ? cur_addr : addr_q;

    // With the buffer empty the word still on rdata_b is presented directly (fall-through).
    assign m_valid = !buf_empty || in_flight_q;
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (!buf_empty) begin
            m_data = buf_data_q[rd_ptr_q];
            m_last = buf_last_q[rd_ptr_q];
        end else if (in_flight_q) begin
            m_data = rdata_b;
            m_last = flight_last_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        stride_d      = stride_q;
        row_d         = row_q;
        col_d         = col_q;
        row_base_d    = row_base_q;
        addr_d        = addr_q;
        done_d        = 1'b0;
        in_flight_d   = issue;
        flight_last_d = issue && last_elem;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (zero_cfg) begin
                        done_d = 1'b1;
                    end else begin
                        rows_d     = row_cnt;
                        cols_d     = col_cnt;
                        stride_d   = row_stride;
                        row_base_d = base_addr;
                        row_d      = '0;
                        col_d      = '0;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = cur_addr;
                    if (row_end) begin
                        col_d      = '0;
                        row_d      = row_q + CNT_WIDTH'(1);
                        row_base_d = ADDR_WIDTH'(CNT_WIDTH'(row_base_q) + stride_q);
                    end else begin
                        col_d = col_q + CNT_WIDTH'(1);
                    end
                    if (last_elem) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged word is the final one, so nothing remains once it is taken.
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_comb begin
                buf_data_d[gi] = buf_data_q[gi];
                buf_last_d[gi] = buf_last_q[gi];
                if (push && (wr_ptr_q == 1'(gi))) begin
                    buf_data_d[gi] = rdata_b;
                    buf_last_d[gi] = flight_last_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_data_q[gi] <= '0;
                    buf_last_q[gi] <= 1'b0;
                end else begin
                    buf_data_q[gi] <= buf_data_d[gi];
                    buf_last_q[gi] <= buf_last_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            stride_q      <= '0;
            row_q         <= '0;
            col_q         <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            in_flight_q   <= 1'b0;
            flight_last_q <= 1'b0;
            done_q        <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            stride_q      <= stride_d;
            row_q         <= row_d;
            col_q         <= col_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            in_flight_q   <= in_flight_d;
            flight_last_q <= flight_last_d;
            done_q        <= done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

endmodule

// File: tb/tb_ifmap_glb_reader.sv
// Directed bench for ifmap_glb_reader: a behavioural GLB with 1-cycle read latency feeds the DUT,
// and every tile is checked against hand-listed address sequences and the preloaded GLB contents.
module tb_ifmap_glb_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [7:0]  row_cnt = '0, col_cnt = '0, row_stride = '0;
    logic        busy, done, re_b, m_valid, m_last;
    logic [3:0]  addr_b;
    logic [15:0] rdata_b = '0;
    logic [15:0] m_data;
    logic        m_ready = 1'b1;

    logic [15:0] glb [16];
    int          exp_addr [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ifmap_glb_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_cnt(row_cnt), .col_cnt(col_cnt), .row_stride(row_stride),
        .busy(busy), .done(done), .re_b(re_b), .addr_b(addr_b), .rdata_b(rdata_b),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always @(posedge clk) begin
        if (re_b) rdata_b <= glb[addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_re_b"}, 32'(re_b), 0);
        check({tag, "_addr_b"}, 32'(addr_b), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_m_last"}, 32'(m_last), 0);
    endtask

    // Runs one tile. repulse >= 1 re-pulses start (with a different config) in that cycle.
    task automatic run_tile(input string tag, input logic [3:0] base, input logic [7:0] rows,
                            input logic [7:0] cols, input logic [7:0] stride, input bit toggle,
                            input int repulse, input int exp_cycles, input int exp_busy);
        int cyc, done_cyc, done_cnt, busy_cnt, issued, accepted, credit_err, stab_err, n_exp;
        bit prev_stall;
        logic [15:0] prev_data;
        logic prev_last;
        logic [3:0] addr_q [$];
        logic [15:0] data_q [$];
        logic last_q [$];
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; issued = 0; accepted = 0;
        credit_err = 0; stab_err = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; row_cnt = rows; col_cnt = cols; row_stride = stride;
        m_ready = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 200 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
            start = (cyc == repulse);
            if (cyc == repulse) begin
                base_addr = 4'd8; row_cnt = 8'd1; col_cnt = 8'd1; row_stride = 8'd0;
            end
            m_ready = toggle ? 1'(cyc % 2) : 1'b1;
            @(negedge clk);
            if (re_b) begin
                if (issued - accepted >= 2) credit_err++;
                addr_q.push_back(addr_b);
                issued++;
            end
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stab_err++;
            if (m_valid && m_ready) begin
                data_q.push_back(m_data);
                last_q.push_back(m_last);
                accepted++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b1;
        n_exp = exp_addr.size();
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_reads"}, 32'(addr_q.size()), 32'(n_exp));
        check({tag, "_words"}, 32'(data_q.size()), 32'(n_exp));
        check({tag, "_credit"}, 32'(credit_err), 0);
        check({tag, "_stable"}, 32'(stab_err), 0);
        if (exp_cycles >= 0) check({tag, "_cycles"}, 32'(done_cyc), 32'(exp_cycles));
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        for (int i = 0; i < n_exp; i++) begin
            if (i < addr_q.size())
                check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr[i]));
            if (i < data_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(data_q[i]), 32'(glb[exp_addr[i]]));
                check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == n_exp - 1));
            end
        end
        $display("tile %s: %0d reads, %0d words, done at cycle %0d", tag, addr_q.size(),
                 data_q.size(), done_cyc);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 16; i++) glb[i] = 16'(16'h1000 + i * 16'h0101);

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        exp_addr = '{0, 1, 2, 4, 5, 6};
        run_tile("t1_basic", 4'd0, 8'd2, 8'd3, 8'd4, 1'b0, -1, 8, 7);
        run_tile("t2_toggle", 4'd0, 8'd2, 8'd3, 8'd4, 1'b1, -1, -1, -1);

        exp_addr = '{14, 15, 0, 1};
        run_tile("t3_wrap", 4'd14, 8'd1, 8'd4, 8'd3, 1'b0, -1, 6, 5);

        exp_addr = {};
        run_tile("t4_zero", 4'd5, 8'd3, 8'd0, 8'd4, 1'b0, -1, 1, 0);

        // Reset in the middle of a tile, right after the third read has gone out.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd0; row_cnt = 8'd2; col_cnt = 8'd3; row_stride = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            if (re_b) seen++;
        end
        check("t5_third_read", 32'(seen), 3);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t5_async");
        @(negedge clk);
        check_reset_outputs("t5_held");
        rst = 1'b0;
        exp_addr = '{0, 1, 2, 4, 5, 6};
        run_tile("t5_after", 4'd0, 8'd2, 8'd3, 8'd4, 1'b0, -1, 8, 7);

        run_tile("t6_busy_start", 4'd0, 8'd2, 8'd3, 8'd4, 1'b0, 3, 8, 7);
        run_tile("t7_done_start", 4'd0, 8'd2, 8'd3, 8'd4, 1'b0, 8, 8, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
